dmi_arbiter: RTL and testbench

Two-requester arbiter sharing the single Debug Module ready/valid DMI bus between the UART-TAP DMI path (port 0) and a second DMI master such as a JTAG DTM (port 1). One transaction is outstanding at a time. The owner is locked from request acceptance until its response is handed back. Sits between the DMI front-ends and the DM; requesters see a private request/response channel pair.

---
 rtl/dmi_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// ---------------------------------------------------------------------------
// dmi_arbiter
//
// Purpose:
//   Shares one Debug Module ready/valid DMI bus between two DMI masters
//   (port 0: UART-TAP DMI path, port 1: e.g. JTAG DTM). Only one transaction
//   is outstanding at a time. The granted port owns the bus from request
//   acceptance until its response has been handed back. Ties are broken
//   round robin, and port 0 wins the first tie after reset.
//
// Ports:
//   CLK_I              clock
//   RST_I              asynchronous active-high reset
//   CLEAR_I            synchronous abort of the current transaction
//   REQ_VALID_I/READY_O[1:0]  per-port request handshake
//   REQ_DATA0_I/1_I    per-port request payload (REQ_W)
//   RESP_VALID_O/READY_I[1:0] per-port response handshake
//   RESP_DATA_O        shared response buffer, qualified by RESP_VALID_O
//   DMI_REQ_*          registered request channel toward the DM
//   DMI_RESP_*         response channel from the DM
//   OWNER_O            index of the current or last owner
//   BUSY_O             high whenever a transaction is in progress
//   TIMEOUT_O          sticky DM watchdog flag (only with DMI_ARB_TIMEOUT_EN)
//
// Build option:
//   DMI_ARB_TIMEOUT_EN  when defined, a watchdog of TIMEOUT_CYCLES cycles
//                       across st_fwd/st_wait turns a hung DM into an
//                       "op failed" response. When undefined the arbiter
//                       waits on the DM indefinitely.
//
// States:
//   st_idle | no transaction; grant and capture a request
//   st_fwd  | request presented to the DM
//   st_wait | waiting for the DM response
//   st_resp | response presented to the owning port
// ---------------------------------------------------------------------------
module dmi_arbiter #(
  parameter int REQ_W          = 41,
  parameter int RESP_W         = 34,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CLEAR_I,
  input  logic [1:0]        REQ_VALID_I,
  output logic [1:0]        REQ_READY_O,
  input  logic [REQ_W-1:0]  REQ_DATA0_I,
  input  logic [REQ_W-1:0]  REQ_DATA1_I,
  output logic [1:0]        RESP_VALID_O,
  input  logic [1:0]        RESP_READY_I,
  output logic [RESP_W-1:0] RESP_DATA_O,
  output logic              DMI_REQ_VALID_O,
  input  logic              DMI_REQ_READY_I,
  output logic [REQ_W-1:0]  DMI_REQ_O,
  input  logic              DMI_RESP_VALID_I,
  output logic              DMI_RESP_READY_O,
  input  logic [RESP_W-1:0] DMI_RESP_I,
  output logic              OWNER_O,
`ifdef DMI_ARB_TIMEOUT_EN
  output logic              TIMEOUT_O,
`endif
  output logic              BUSY_O
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Response reported when the DM watchdog fires: data 0, resp 2 (op failed).
  localparam logic [RESP_W-1:0] TIMEOUT_RESP = RESP_W'(2'h2);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dmi_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_owner;
  logic              r_last_served;
  logic [REQ_W-1:0]  r_dmi_req;
  logic [RESP_W-1:0] r_resp_data;

  logic w_grant;
  logic w_accept;
  logic w_fwd_done;
  logic w_resp_in;
  logic w_resp_out;
  logic w_resp_done;
  logic w_timeout;

  // Sole valid port wins; on a tie the port not served last wins.
  assign w_grant     = (REQ_VALID_I == 2'b11) ? ~r_last_served : REQ_VALID_I[1];

  // CLEAR_I masks every handshake so nothing transfers in the abort cycle.
  assign w_accept    = (r_state == ST_IDLE) && (|REQ_VALID_I) && !CLEAR_I;
  assign w_fwd_done  = (r_state == ST_FWD)  && DMI_REQ_READY_I  && !CLEAR_I;
  assign w_resp_in   = (r_state == ST_WAIT) && DMI_RESP_VALID_I && !CLEAR_I;
  assign w_resp_out  = (r_state == ST_RESP) && !CLEAR_I;
  assign w_resp_done = w_resp_out && RESP_READY_I[r_owner];

  assign REQ_READY_O      = {w_accept & w_grant, w_accept & ~w_grant};
  assign RESP_VALID_O     = {w_resp_out & r_owner, w_resp_out & ~r_owner};
  assign DMI_REQ_VALID_O  = (r_state == ST_FWD)  && !CLEAR_I;
  assign DMI_RESP_READY_O = (r_state == ST_WAIT) && !CLEAR_I;
  assign DMI_REQ_O        = r_dmi_req;
  assign RESP_DATA_O      = r_resp_data;
  assign OWNER_O          = r_owner;
  assign BUSY_O           = (r_state != ST_IDLE);

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Expiry only when the awaited handshake is absent; a handshake in the
  // expiry cycle takes precedence.
  assign w_timeout = !CLEAR_I && (r_cnt == CNT_LAST) &&
                     (((r_state == ST_FWD)  && !DMI_REQ_READY_I) ||
                      ((r_state == ST_WAIT) && !DMI_RESP_VALID_I));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (CLEAR_I) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == ST_FWD) || (r_state == ST_WAIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign TIMEOUT_O = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_FWD;
      ST_FWD: begin
        if (w_fwd_done)     w_state_nxt = ST_WAIT;
        else if (w_timeout) w_state_nxt = ST_RESP;
      end
      ST_WAIT: begin
        if (w_resp_in || w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RESP: if (w_resp_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (CLEAR_I) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_dmi_req     <= '0;
      r_resp_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (CLEAR_I) begin
        // Ownership history survives an abort; payload buffers do not.
        r_dmi_req   <= '0;
        r_resp_data <= '0;
      end else begin
        if (w_accept) begin
          r_dmi_req <= w_grant ? REQ_DATA1_I : REQ_DATA0_I;
          r_owner   <= w_grant;
        end
        if (w_resp_in) begin
          r_resp_data <= DMI_RESP_I;
        end else if (w_timeout) begin
          r_resp_data <= TIMEOUT_RESP;
        end
        if (w_resp_done) begin
          r_last_served <= r_owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
module tb_dmi_arbiter;
  localparam int REQ_W  = 41;
  localparam int RESP_W = 34;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [REQ_W-1:0]  req_data0;
  logic [REQ_W-1:0]  req_data1;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [RESP_W-1:0] resp_data_o;
  logic              dmi_req_valid;
  logic              dmi_req_ready;
  logic [REQ_W-1:0]  dmi_req_o;
  logic              dmi_resp_valid;
  logic              dmi_resp_ready;
  logic [RESP_W-1:0] dmi_resp;
  logic              owner;
  logic              busy;
`ifdef DMI_ARB_TIMEOUT_EN
  logic              timeout;
`endif

  always #5 clk = ~clk;

  dmi_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .TIMEOUT_CYCLES(8)) dut (
    .CLK_I            (clk),
    .RST_I            (rst),
    .CLEAR_I          (clear),
    .REQ_VALID_I      (req_valid),
    .REQ_READY_O      (req_ready),
    .REQ_DATA0_I      (req_data0),
    .REQ_DATA1_I      (req_data1),
    .RESP_VALID_O     (resp_valid),
    .RESP_READY_I     (resp_ready),
    .RESP_DATA_O      (resp_data_o),
    .DMI_REQ_VALID_O  (dmi_req_valid),
    .DMI_REQ_READY_I  (dmi_req_ready),
    .DMI_REQ_O        (dmi_req_o),
    .DMI_RESP_VALID_I (dmi_resp_valid),
    .DMI_RESP_READY_O (dmi_resp_ready),
    .DMI_RESP_I       (dmi_resp),
    .OWNER_O          (owner),
`ifdef DMI_ARB_TIMEOUT_EN
    .TIMEOUT_O        (timeout),
`endif
    .BUSY_O           (busy)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected DM requests and expected {resp_valid, resp_data}.
  logic [REQ_W-1:0]  q_req[$];
  logic [RESP_W+1:0] q_rsp[$];
  logic [REQ_W-1:0]  mon_req;
  logic [RESP_W+1:0] mon_rsp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s %s", name, what);
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [6:0] a, input logic [1:0] op,
                                              input logic [31:0] d);
    return {a, op, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dm_accept(input int rdy_dly);
    int n;
    n = 0;
    while (!dmi_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!dmi_req_valid) begin
      fail_msg("dm_req_wait", "no DMI request within 20 cycles");
    end else begin
      repeat (rdy_dly) tick();
      dmi_req_ready = 1'b1;
      tick();
      dmi_req_ready = 1'b0;
    end
  endtask

  task automatic dm_respond(input int dly, input logic [RESP_W-1:0] r);
    repeat (dly) tick();
    dmi_resp_valid = 1'b1;
    dmi_resp       = r;
    tick();
    dmi_resp_valid = 1'b0;
    dmi_resp       = '0;
  endtask

  task automatic host_take(input logic port, input int dly);
    int n;
    n = 0;
    while (!resp_valid[port] && n < 20) begin
      tick();
      n++;
    end
    if (!resp_valid[port]) begin
      fail_msg("resp_wait", "no response within 20 cycles");
    end else begin
      repeat (dly) tick();
      resp_ready[port] = 1'b1;
      tick();
      resp_ready[port] = 1'b0;
    end
  endtask

  // Monitor: compares every completed transfer against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmi_req_valid && dmi_req_ready) begin
        if (q_req.size() == 0) begin
          fail_msg("dmi_req_unexpected", "DM request transfer with nothing expected");
        end else begin
          mon_req = q_req.pop_front();
          chk("dmi_req_data", 64'(dmi_req_o), 64'(mon_req));
        end
      end
      if ((resp_valid & resp_ready) != 2'b00) begin
        if (q_rsp.size() == 0) begin
          fail_msg("resp_unexpected", "response transfer with nothing expected");
        end else begin
          mon_rsp = q_rsp.pop_front();
          chk("resp_port_data", 64'({resp_valid, resp_data_o}), 64'(mon_rsp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [REQ_W-1:0]  d0, d1;
  logic [RESP_W-1:0] ra, rb;
  logic [1:0]        exp_oh;

  initial begin
    rst = 1'b1; clear = 1'b0;
    req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
    resp_ready = 2'b00; dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b0; dmi_resp = '0;
    tick(); tick(); settle();

    chk("reset_handshakes", 64'({dmi_req_valid, dmi_resp_ready, req_ready, resp_valid}), 64'(6'b0));
    chk("reset_dmi_req", 64'(dmi_req_o), 64'(0));
    chk("reset_resp_data", 64'(resp_data_o), 64'(0));
    chk("reset_owner_busy", 64'({owner, busy}), 64'(2'b00));
    rst = 1'b0;
    tick();

    // Port 0 alone, read of 0x10.
    d0 = mk_req(7'h10, 2'h1, 32'h0);
    ra = {32'hDEADBEEF, 2'b00};
    req_data0 = d0;
    q_req.push_back(d0);
    q_rsp.push_back({2'b01, ra});
    req_valid = 2'b01; settle();
    chk("t1_req_ready", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b00; settle();
    chk("t1_fwd_next_cycle", 64'({dmi_req_valid, busy, owner}), 64'(3'b110));
    dm_accept(0); settle();
    chk("t1_wait_ready", 64'({dmi_resp_ready, dmi_req_valid}), 64'(2'b10));
    dm_respond(3, ra); settle();
    chk("t1_resp_valid", 64'(resp_valid), 64'(2'b01));
    host_take(1'b0, 0); settle();
    chk("t1_busy_drop", 64'(busy), 64'(0));

    // Simultaneous pair straight out of reset: port 0 first, then port 1.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    d0 = mk_req(7'h11, 2'h2, 32'h1111_0000);
    d1 = mk_req(7'h21, 2'h2, 32'h2222_0000);
    ra = {32'hAAAA_0001, 2'b00};
    rb = {32'hBBBB_0002, 2'b00};
    req_data0 = d0; req_data1 = d1;
    q_req.push_back(d0); q_req.push_back(d1);
    q_rsp.push_back({2'b01, ra}); q_rsp.push_back({2'b10, rb});
    req_valid = 2'b11; settle();
    chk("t2_first_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b10; settle();
    chk("t2_p1_held_fwd", 64'(req_ready), 64'(2'b00));
    dm_accept(0);
    dm_respond(1, ra); settle();
    chk("t2_p1_held_resp", 64'(req_ready), 64'(2'b00));
    host_take(1'b0, 0); settle();
    chk("t2_second_grant", 64'(req_ready), 64'(2'b10));
    tick(); req_valid = 2'b00;
    dm_accept(0);
    dm_respond(1, rb);
    host_take(1'b1, 0);

    // Repeated simultaneous pairs alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      d0 = mk_req(7'h30, 2'h1, 32'hA000_0000 + 32'(k));
      d1 = mk_req(7'h31, 2'h1, 32'hB000_0000 + 32'(k));
      ra = {32'hC000_0000 + 32'(k), 2'b00};
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      req_data0 = d0; req_data1 = d1;
      q_req.push_back((k % 2 == 0) ? d0 : d1);
      q_rsp.push_back({exp_oh, ra});
      req_valid = 2'b11; settle();
      chk("t2_alternation", 64'(req_ready), 64'(exp_oh));
      tick(); req_valid = 2'b00;
      dm_accept(0);
      dm_respond(0, ra);
      host_take(exp_oh[1], 0);
    end

    // DM stalls request ready for 5 cycles; request must stay put.
    d1 = mk_req(7'h05, 2'h2, 32'hCAFE_F00D);
    ra = {32'h1234_5678, 2'b00};
    req_data1 = d1;
    q_req.push_back(d1);
    q_rsp.push_back({2'b10, ra});
    req_valid = 2'b10; settle();
    chk("t3_grant", 64'(req_ready), 64'(2'b10));
    tick(); req_valid = 2'b00; req_data1 = '1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3_stall_valid", 64'(dmi_req_valid), 64'(1));
      chk("t3_stall_data", 64'(dmi_req_o), 64'(d1));
      tick();
    end
    dm_accept(0);
    dm_respond(2, ra);
    host_take(1'b1, 0);

    // Owner delays response ready 4 cycles while the other port waits.
    d0 = mk_req(7'h16, 2'h1, 32'h0);
    d1 = mk_req(7'h26, 2'h2, 32'h5555_AAAA);
    ra = {32'h0BAD_F00D, 2'b00};
    rb = {32'h0000_0026, 2'b00};
    req_data0 = d0; req_data1 = d1;
    q_req.push_back(d0); q_req.push_back(d1);
    q_rsp.push_back({2'b01, ra}); q_rsp.push_back({2'b10, rb});
    req_valid = 2'b01; settle();
    chk("t4_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b10;
    dm_accept(0);
    dm_respond(1, ra);
    dmi_resp_valid = 1'b1; dmi_resp = 34'h3_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_no_grant", 64'(req_ready), 64'(2'b00));
      chk("t4_resp_valid", 64'(resp_valid), 64'(2'b01));
      chk("t4_resp_stable", 64'(resp_data_o), 64'(ra));
      tick();
    end
    dmi_resp_valid = 1'b0; dmi_resp = '0;
    resp_ready[0] = 1'b1; settle();
    chk("t4_no_grant_on_done", 64'(req_ready), 64'(2'b00));
    tick(); resp_ready[0] = 1'b0; settle();
    chk("t4_next_grant", 64'(req_ready), 64'(2'b10));
    tick(); req_valid = 2'b00;
    dm_accept(0);
    dm_respond(1, rb);
    host_take(1'b1, 0);

    // CLEAR_I in st_wait with a DM response offered in the same cycle.
    d0 = mk_req(7'h17, 2'h1, 32'h0);
    req_data0 = d0;
    q_req.push_back(d0);
    req_valid = 2'b01; settle();
    chk("t5_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b00;
    dm_accept(0); settle();
    chk("t5_in_wait", 64'(dmi_resp_ready), 64'(1));
    dmi_resp_valid = 1'b1; dmi_resp = 34'h1_2345_6789; clear = 1'b1; settle();
    chk("t5_clear_handshakes", 64'({dmi_req_valid, dmi_resp_ready, req_ready, resp_valid}), 64'(6'b0));
    tick(); clear = 1'b0; settle();
    chk("t5_idle", 64'(busy), 64'(0));
    chk("t5_resp_zeroed", 64'(resp_data_o), 64'(0));
    chk("t5_req_zeroed", 64'(dmi_req_o), 64'(0));
    chk("t5_no_resp", 64'({resp_valid, dmi_resp_ready}), 64'(3'b000));
    tick(); dmi_resp_valid = 1'b0; dmi_resp = '0; settle();
    chk("t5_still_idle", 64'(busy), 64'(0));
    // Port 1 was served last before the abort, so port 0 wins this tie.
    d0 = mk_req(7'h19, 2'h1, 32'h0);
    ra = {32'h7777_7777, 2'b00};
    req_data0 = d0; req_data1 = mk_req(7'h29, 2'h1, 32'h0);
    q_req.push_back(d0);
    q_rsp.push_back({2'b01, ra});
    req_valid = 2'b11; settle();
    chk("t5_rr_unchanged", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b00;
    dm_accept(0);
    dm_respond(1, ra);
    host_take(1'b0, 0);

`ifdef DMI_ARB_TIMEOUT_EN
    // DM never answers; watchdog of 8 cycles across st_fwd/st_wait.
    d0 = mk_req(7'h18, 2'h1, 32'h0);
    req_data0 = d0;
    q_rsp.push_back({2'b01, 34'h2});
    req_valid = 2'b01; settle();
    chk("t6_grant", 64'(req_ready), 64'(2'b01));
    tick(); req_valid = 2'b00; settle();
    chk("t6_flag_low", 64'(timeout), 64'(0));
    repeat (7) tick();
    settle();
    chk("t6_before_expiry", 64'({dmi_req_valid, resp_valid}), 64'(3'b100));
    tick(); settle();
    chk("t6_expired", 64'({timeout, resp_valid}), 64'(3'b101));
    chk("t6_resp_data", 64'(resp_data_o), 64'(34'h2));
    host_take(1'b0, 0); settle();
    chk("t6_flag_sticky", 64'(timeout), 64'(1));
    clear = 1'b1; tick(); clear = 1'b0; settle();
    chk("t6_flag_cleared", 64'(timeout), 64'(0));
`endif

    tick(); tick(); tick();
    chk("sb_req_drained", 64'(q_req.size()), 64'(0));
    chk("sb_rsp_drained", 64'(q_rsp.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
